pga_autorange_ctrl: RTL and testbench
=====================================

// Module: pga_autorange_ctrl
// PURPOSE
//  Multi-channel PGA gain controller for the ECT front end; successor to the fixed 2-channel gain latch.
//  Holds a commanded base gain per channel; in auto mode each measurement starts at the base gain.
//  Gain then steps down one code per window while the ADC overrange flag (OTR) fires too often.
//  Sits between the command decoder / measurement sequencer and the PGA G2..G0 pins.
//  Raises GainValid once every channel has settled, so the sequencer can start ADC capture.
// PARAMETERS
//  NCH       2    number of PGA/ADC channels
//  GW        3    gain code width per channel (code 0 = 0.08, code 7 = 10.0)
//  DEF_GAIN  3    gain code loaded at reset
//  SETTLE_CYC 64  CLK cycles waited after any gain change before OTR is observed
//  WIN_CYC   256  OTR observation window length, CLK cycles
//  OTR_LIM   4    OTR-high cycles within one window that force a step down
//  ADDR_W    9    SwitchAddr width
// PORTS
//  CLK        in   1         system clock
//  RST        in   1         asynchronous reset, active low
//  SetTrig    in   1         1-cycle pulse: latch CfgGain/CfgAuto
//  CfgGain    in   NCH*GW    base gain per channel, ch0 in [GW-1:0]
//  CfgAuto    in   1         1 = auto-ranging, 0 = manual (fixed gain)
//  MeasStart  in   1         1-cycle pulse at the start of each electrode-pair measurement
//  SwitchAddr in   ADDR_W    current measurement index (registered into MeasIdx only)
//  AdjPair    in   1         current pair is adjacent electrodes (used only with macro)
//  ADOtr      in   NCH       ADC overrange flags, synchronous to CLK
//  PGA        out  NCH*GW    gain bus to PGA pins, registered
//  GainValid  out  1         all channels in DONE state
//  GainChg    out  NCH       1-cycle pulse when a channel's gain steps
//  OtrSticky  out  NCH       channel hit GAIN_MIN and still overranged; cleared on MeasStart
//  MeasIdx    out  ADDR_W    SwitchAddr captured at MeasStart (tags the gains)
// BEHAVIOUR
//  Reset: PGA = DEF_GAIN per channel; base = DEF_GAIN; auto = 0.
//   All channel FSMs in IDLE; GainValid = 0, GainChg = 0, OtrSticky = 0, MeasIdx = 0.
//  SetTrig: base <= CfgGain, auto <= CfgAuto next edge.
//   In manual mode PGA <= CfgGain on the same edge; FSM restarts SETTLE if active.
//  Per-channel FSM, states IDLE, SETTLE, OBSERVE, DONE:
//   IDLE/DONE --MeasStart--> SETTLE. On that edge PGA <= base (auto) and OtrSticky cleared.
//    MeasStart in SETTLE/OBSERVE also restarts SETTLE with base reload.
//   SETTLE: counter 0..SETTLE_CYC-1, then OBSERVE; OTR ignored.
//   OBSERVE: counts ADOtr-high cycles over WIN_CYC cycles; counter saturates at OTR_LIM.
//   Window end, cnt >= OTR_LIM, auto, gain > 0: gain -= 1, GainChg pulse, back to SETTLE.
//   Window end, cnt >= OTR_LIM, gain == 0: set OtrSticky, -> DONE.
//   Window end otherwise, or manual mode: -> DONE. Gain never steps up within a measurement.
//  GainValid = AND of all channels in DONE, registered (1-cycle lag from last DONE entry).
//   GainValid drops on the edge MeasStart is sampled.
//  Gain arithmetic is unsigned GW-bit; decrement never wraps below 0.
//  Simultaneous SetTrig + MeasStart: the new CfgGain is the base used by that MeasStart.
//  Async reset mid-measurement returns every output to its reset value immediately.
// CONFIGURATION
//  `PGA_ADJ_BOOST_EN defined: base used at MeasStart = CfgGain when AdjPair = 1.
//   Otherwise base = CfgGain + 1, saturating at 2**GW-1 (non-adjacent pairs see smaller signals).
//  Not defined: AdjPair ignored; base = CfgGain for every pair.
// STRUCTURE
//  pga_defs.vh: FSM state encodings (2-bit), GAIN_MIN = 0, GAIN_MAX = 2**GW-1, counter width macros.
//  Sub-module pga_chan_fsm: one channel (FSM, settle/window/OTR counters, gain register).
//   Instantiated NCH times in a generate loop; the top holds config regs, GainValid, MeasIdx.
// TESTING
//  Reset, no stimulus -> PGA = {3,3}, GainValid = 0, OtrSticky = 0.
//  Manual: CfgGain = {5,2}, SetTrig, MeasStart, ADOtr = 2'b11 held -> PGA stays {5,2}.
//   GainValid = 1 after SETTLE_CYC + WIN_CYC + 2 cycles; GainChg never pulses.
//  Auto ch0: base 5, ADOtr[0] high for 2 full windows -> PGA[0] 5 -> 4 -> 3, two GainChg[0] pulses.
//   Then OTR low -> DONE at 3; ch1 unchanged at base.
//  Auto floor: base 0, ADOtr[0] stuck high -> no decrement, OtrSticky[0] = 1, GainValid = 1.
//   Next MeasStart clears OtrSticky.
//  MeasStart during OBSERVE with gain already stepped to 2 from base 4 -> PGA = 4 next edge.
//   SETTLE restarts and MeasIdx updates.
//  With `PGA_ADJ_BOOST_EN, CfgGain 3: AdjPair = 0 -> PGA 4; AdjPair = 1 -> PGA 3; CfgGain 7, AdjPair = 0 -> PGA 7.

Source files
------------

// File: rtl/pga_autorange_ctrl_pkg.sv
// Shared definitions for the PGA auto-ranging controller: channel FSM states and gain limits.
package pga_autorange_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_OBSERVE = 2'd2,
    ST_DONE    = 2'd3
  } chan_state_t;

  localparam int GAIN_MIN = 0;

  function automatic int gain_max(input int gw);
    return (1 << gw) - 1;
  endfunction

endpackage

// File: rtl/pga_autorange_ctrl_if.sv
// Command/sequencer/ADC side bus of the PGA auto-ranging controller.
interface pga_autorange_ctrl_if #(
  parameter int NCH    = 2,
  parameter int GW     = 3,
  parameter int ADDR_W = 9
);
  logic                SetTrig;
  logic [NCH*GW-1:0]   CfgGain;
  logic                CfgAuto;
  logic                MeasStart;
  logic [ADDR_W-1:0]   SwitchAddr;
  logic                AdjPair;
  logic [NCH-1:0]      ADOtr;
  logic [NCH*GW-1:0]   PGA;
  logic                GainValid;
  logic [NCH-1:0]      GainChg;
  logic [NCH-1:0]      OtrSticky;
  logic [ADDR_W-1:0]   MeasIdx;

  modport master (
    output SetTrig, CfgGain, CfgAuto, MeasStart, SwitchAddr, AdjPair, ADOtr,
    input  PGA, GainValid, GainChg, OtrSticky, MeasIdx
  );

  modport slave (
    input  SetTrig, CfgGain, CfgAuto, MeasStart, SwitchAddr, AdjPair, ADOtr,
    output PGA, GainValid, GainChg, OtrSticky, MeasIdx
  );
endinterface

// File: rtl/pga_autorange_ctrl_chan_fsm.sv
// One PGA channel: gain register, settle/window counters and overrange stepping FSM.
module pga_chan_fsm
  import pga_autorange_ctrl_pkg::*;
#(
  parameter int GW         = 3,
  parameter int DEF_GAIN   = 3,
  parameter int SETTLE_CYC = 64,
  parameter int WIN_CYC    = 256,
  parameter int OTR_LIM    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          meas_start,
  input  logic          set_manual,
  input  logic          auto_en,
  input  logic [GW-1:0] base,
  input  logic [GW-1:0] man_gain,
  input  logic          otr,
  output logic [GW-1:0] gain,
  output logic          done,
  output logic          chg,
  output logic          sticky
);

  localparam int CW = $clog2((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC);
  localparam int OW = $clog2(OTR_LIM + 1);

  chan_state_t   state;
  logic [CW-1:0] cnt;
  logic [OW-1:0] otr_cnt;
  logic [OW-1:0] otr_nxt;
  logic          win_end;
  logic          over;
  logic          at_floor;

  function automatic logic [OW-1:0] otr_sat_inc(input logic [OW-1:0] c, input logic hit);
    return (hit && (c != OW'(OTR_LIM))) ? c + 1'b1 : c;
  endfunction

  function automatic logic [GW-1:0] gain_dec(input logic [GW-1:0] g);
    return (g == GW'(GAIN_MIN)) ? g : g - 1'b1;
  endfunction

  assign otr_nxt  = otr_sat_inc(otr_cnt, otr);
  assign win_end  = (state == ST_OBSERVE) && (cnt == CW'(WIN_CYC - 1));
  assign over     = (otr_nxt >= OW'(OTR_LIM));
  assign at_floor = (gain == GW'(GAIN_MIN));
  assign done     = (state == ST_DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      otr_cnt <= '0;
      gain    <= GW'(DEF_GAIN);
      chg     <= 1'b0;
      sticky  <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (meas_start) begin
        state   <= ST_SETTLE;
        cnt     <= '0;
        otr_cnt <= '0;
        sticky  <= 1'b0;
        if (set_manual)   gain <= man_gain;
        else if (auto_en) gain <= base;
      end else if (set_manual) begin
        // A manual gain change invalidates any settling already done.
        gain <= man_gain;
        if ((state == ST_SETTLE) || (state == ST_OBSERVE)) begin
          state   <= ST_SETTLE;
          cnt     <= '0;
          otr_cnt <= '0;
        end
      end else begin
        case (state)
          ST_SETTLE: begin
            if (cnt == CW'(SETTLE_CYC - 1)) begin
              state   <= ST_OBSERVE;
              cnt     <= '0;
              otr_cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_OBSERVE: begin
            cnt     <= cnt + 1'b1;
            otr_cnt <= otr_nxt;
            if (win_end) begin
              cnt     <= '0;
              otr_cnt <= '0;
              if (over && at_floor) begin
                sticky <= 1'b1;
                state  <= ST_DONE;
              end else if (over && auto_en) begin
                gain  <= gain_dec(gain);
                chg   <= 1'b1;
                state <= ST_SETTLE;
              end else begin
                state <= ST_DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/pga_autorange_ctrl.sv
// Multi-channel PGA gain controller with per-measurement auto-ranging on ADC overrange.
// Optional PGA_ADJ_BOOST_EN: non-adjacent pairs start one gain code above the commanded base.
module pga_autorange_ctrl
  import pga_autorange_ctrl_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int GW         = 3,
  parameter int DEF_GAIN   = 3,
  parameter int SETTLE_CYC = 64,
  parameter int WIN_CYC    = 256,
  parameter int OTR_LIM    = 4,
  parameter int ADDR_W     = 9
) (
  input  logic                 CLK,
  input  logic                 RST,
  pga_autorange_ctrl_if.slave  bus
);

  logic [NCH*GW-1:0] base_r;
  logic              auto_r;
  logic              auto_sel;
  logic              set_manual;
  logic [NCH-1:0]    done;
  logic              gain_valid;
  logic [ADDR_W-1:0] meas_idx;

  function automatic logic [GW-1:0] gain_sat_inc(input logic [GW-1:0] g);
    return (g == GW'(gain_max(GW))) ? g : g + 1'b1;
  endfunction

  // A SetTrig coincident with MeasStart supplies the configuration for that measurement.
  assign auto_sel   = bus.SetTrig ? bus.CfgAuto : auto_r;
  assign set_manual = bus.SetTrig & ~bus.CfgAuto;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    logic [GW-1:0] base_sel;
    logic [GW-1:0] base_eff;

    assign base_sel = bus.SetTrig ? bus.CfgGain[ch*GW +: GW] : base_r[ch*GW +: GW];
`ifdef PGA_ADJ_BOOST_EN
    assign base_eff = bus.AdjPair ? base_sel : gain_sat_inc(base_sel);
`else
    assign base_eff = base_sel;
`endif

    pga_chan_fsm #(
      .GW         (GW),
      .DEF_GAIN   (DEF_GAIN),
      .SETTLE_CYC (SETTLE_CYC),
      .WIN_CYC    (WIN_CYC),
      .OTR_LIM    (OTR_LIM)
    ) u_chan (
      .CLK        (CLK),
      .RST        (RST),
      .meas_start (bus.MeasStart),
      .set_manual (set_manual),
      .auto_en    (auto_sel),
      .base       (base_eff),
      .man_gain   (bus.CfgGain[ch*GW +: GW]),
      .otr        (bus.ADOtr[ch]),
      .gain       (bus.PGA[ch*GW +: GW]),
      .done       (done[ch]),
      .chg        (bus.GainChg[ch]),
      .sticky     (bus.OtrSticky[ch])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      base_r     <= {NCH{GW'(DEF_GAIN)}};
      auto_r     <= 1'b0;
      gain_valid <= 1'b0;
      meas_idx   <= '0;
    end else begin
      if (bus.SetTrig) begin
        base_r <= bus.CfgGain;
        auto_r <= bus.CfgAuto;
      end
      if (bus.MeasStart) meas_idx <= bus.SwitchAddr;
      gain_valid <= bus.MeasStart ? 1'b0 : &done;
    end
  end

  assign bus.GainValid = gain_valid;
  assign bus.MeasIdx   = meas_idx;

endmodule

// File: tb/tb_pga_autorange_ctrl.sv
// Scoreboard bench for pga_autorange_ctrl: expected gain steps and completions are queued at stimulus time.
module tb_pga_autorange_ctrl;

  localparam int NCH = 2, GW = 3, ADDR_W = 9;
  localparam int SETTLE = 64, WIN = 256;

  typedef struct {
    logic [5:0] pga;
    logic [1:0] sticky;
    logic [8:0] idx;
    int         lat;
  } done_t;

  typedef struct {
    logic [1:0] chg;
    logic [5:0] pga;
  } chg_t;

  logic  CLK;
  logic  RST;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    meas_edge = 0;
  done_t exp_done[$];
  chg_t  exp_chg[$];

  pga_autorange_ctrl_if #(.NCH(NCH), .GW(GW), .ADDR_W(ADDR_W)) bus ();

  pga_autorange_ctrl #(
    .NCH(NCH), .GW(GW), .DEF_GAIN(3), .SETTLE_CYC(SETTLE),
    .WIN_CYC(WIN), .OTR_LIM(4), .ADDR_W(ADDR_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_done(input logic [5:0] pga, input logic [1:0] st, input logic [8:0] idx, input int lat);
    done_t d;
    d.pga = pga; d.sticky = st; d.idx = idx; d.lat = lat;
    exp_done.push_back(d);
  endtask

  task automatic push_chg(input logic [1:0] c, input logic [5:0] pga);
    chg_t e;
    e.chg = c; e.pga = pga;
    exp_chg.push_back(e);
  endtask

  // Drives one command cycle; returns 1 time unit after the edge that sampled it.
  task automatic issue(input bit set, input bit meas, input logic [5:0] g, input bit a, input logic [8:0] addr);
    @(posedge CLK); #1;
    bus.SetTrig   = set;
    bus.MeasStart = meas;
    if (set) begin
      bus.CfgGain = g;
      bus.CfgAuto = a;
    end
    bus.SwitchAddr = addr;
    @(posedge CLK); #1;
    bus.SetTrig   = 1'b0;
    bus.MeasStart = 1'b0;
  endtask

  task automatic wait_gv(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      if (bus.GainValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL gv_timeout: GainValid still low after %0d cycles, required high", max);
    end
  endtask

  // Edge counter; remembers which edge sampled the latest MeasStart.
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      if (bus.MeasStart === 1'b1) meas_edge = cyc;
    end
  end

  // Monitor: pops expectations whenever the DUT reports a gain step or completion.
  initial begin
    logic  gv_q;
    chg_t  c;
    done_t d;
    gv_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1) begin
        if (bus.GainChg !== 2'b00) begin
          if (exp_chg.size() == 0) begin
            chk("chg_unexpected", 32'(bus.GainChg), 32'd0);
          end else begin
            c = exp_chg.pop_front();
            chk("chg_vec", 32'(bus.GainChg), 32'(c.chg));
            chk("chg_pga", 32'(bus.PGA), 32'(c.pga));
          end
        end
        if (bus.GainValid === 1'b1 && !gv_q) begin
          if (exp_done.size() == 0) begin
            chk("gv_unexpected", 32'(bus.GainValid), 32'd0);
          end else begin
            d = exp_done.pop_front();
            chk("done_pga", 32'(bus.PGA), 32'(d.pga));
            chk("done_sticky", 32'(bus.OtrSticky), 32'(d.sticky));
            chk("done_idx", 32'(bus.MeasIdx), 32'(d.idx));
            chk("done_latency", 32'(cyc - meas_edge + 1), 32'(d.lat));
          end
        end
        gv_q = bus.GainValid;
      end else begin
        gv_q = 1'b0;
      end
    end
  end

  initial begin
    bus.SetTrig    = 1'b0;
    bus.CfgGain    = '0;
    bus.CfgAuto    = 1'b0;
    bus.MeasStart  = 1'b0;
    bus.SwitchAddr = '0;
    bus.AdjPair    = 1'b1;
    bus.ADOtr      = '0;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_pga", 32'(bus.PGA), 32'o33);
    chk("rst_gv", 32'(bus.GainValid), 32'd0);
    chk("rst_sticky", 32'(bus.OtrSticky), 32'd0);
    chk("rst_idx", 32'(bus.MeasIdx), 32'd0);

    // Manual mode: gain fixed despite constant overrange
    issue(1'b1, 1'b0, 6'o52, 1'b0, 9'h000);
    chk("man_set_pga", 32'(bus.PGA), 32'o52);
    bus.ADOtr = 2'b11;
    push_done(6'o52, 2'b00, 9'h021, SETTLE + WIN + 2);
    issue(1'b0, 1'b1, 6'o00, 1'b0, 9'h021);
    chk("man_start_pga", 32'(bus.PGA), 32'o52);
    wait_gv(400);

    // Auto: ch0 steps 5 -> 4 -> 3 over two overranged windows, ch1 stays at 6
    bus.ADOtr = 2'b01;
    push_chg(2'b01, 6'o64);
    push_chg(2'b01, 6'o63);
    push_done(6'o63, 2'b00, 9'h042, 3 * (SETTLE + WIN) + 2);
    issue(1'b1, 1'b1, 6'o65, 1'b1, 9'h042);
    chk("auto_start_pga", 32'(bus.PGA), 32'o65);
    chk("auto_gv_drop", 32'(bus.GainValid), 32'd0);
    repeat (680) @(posedge CLK);
    #1 bus.ADOtr = 2'b00;
    wait_gv(400);

    // Floor: ch0 at code 0 with overrange stuck high
    bus.ADOtr = 2'b01;
    issue(1'b1, 1'b0, 6'o10, 1'b1, 9'h000);
    chk("floor_set_pga", 32'(bus.PGA), 32'o63);
    push_done(6'o10, 2'b01, 9'h063, SETTLE + WIN + 2);
    issue(1'b0, 1'b1, 6'o00, 1'b0, 9'h063);
    chk("floor_start_pga", 32'(bus.PGA), 32'o10);
    wait_gv(400);
    bus.ADOtr = 2'b00;
    issue(1'b0, 1'b1, 6'o00, 1'b0, 9'h064);
    chk("sticky_clear", 32'(bus.OtrSticky), 32'd0);
    chk("sticky_gv_drop", 32'(bus.GainValid), 32'd0);
    chk("sticky_idx", 32'(bus.MeasIdx), 32'h064);

    // Restart during OBSERVE after stepping 4 -> 2
    bus.ADOtr = 2'b01;
    push_chg(2'b01, 6'o43);
    push_chg(2'b01, 6'o42);
    issue(1'b1, 1'b1, 6'o44, 1'b1, 9'h085);
    chk("restart_base_pga", 32'(bus.PGA), 32'o44);
    repeat (715) @(posedge CLK);
    #1;
    chk("restart_stepped_pga", 32'(bus.PGA), 32'o42);
    bus.ADOtr = 2'b00;
    push_done(6'o44, 2'b00, 9'h0A6, SETTLE + WIN + 2);
    issue(1'b0, 1'b1, 6'o00, 1'b0, 9'h0A6);
    chk("restart_reload_pga", 32'(bus.PGA), 32'o44);
    chk("restart_idx", 32'(bus.MeasIdx), 32'h0A6);
    chk("restart_gv", 32'(bus.GainValid), 32'd0);
    wait_gv(400);

    // Adjacent-pair boost (or its absence in the default build)
    bus.AdjPair = 1'b0;
    issue(1'b1, 1'b1, 6'o73, 1'b1, 9'h0C7);
`ifdef PGA_ADJ_BOOST_EN
    chk("boost_nonadj_pga", 32'(bus.PGA), 32'o74);
`else
    chk("noboost_nonadj_pga", 32'(bus.PGA), 32'o73);
`endif
    bus.AdjPair = 1'b1;
    issue(1'b0, 1'b1, 6'o00, 1'b0, 9'h0C8);
    chk("adj_pga", 32'(bus.PGA), 32'o73);

    // Asynchronous reset mid-measurement
    repeat (100) @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    chk("arst_pga", 32'(bus.PGA), 32'o33);
    chk("arst_idx", 32'(bus.MeasIdx), 32'd0);
    chk("arst_gv", 32'(bus.GainValid), 32'd0);
    chk("arst_sticky", 32'(bus.OtrSticky), 32'd0);
    chk("arst_chg", 32'(bus.GainChg), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (5) @(posedge CLK);

    chk("pending_done", 32'(exp_done.size()), 32'd0);
    chk("pending_chg", 32'(exp_chg.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
